// File: rtl/ula_pkg.sv
// ula_pkg: OP codes, FSM states and func field constants shared by ula_exec.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro: ULA_MUL_EN (shift-add multiply).
package ula_pkg;

  // 4-bit ALU operation codes
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1011;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b1110;
  localparam logic [3:0] OP_SEQ = 4'b1111;
  localparam logic [3:0] OP_MUL = 4'b0110;

  // R-type func[3:0] codes
  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_NOR = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_AND = 4'd4;
  localparam logic [3:0] F_XOR = 4'd5;
  localparam logic [3:0] F_SLL = 4'd6;
  localparam logic [3:0] F_SRL = 4'd7;
  localparam logic [3:0] F_SLT = 4'd8;
  localparam logic [3:0] F_SEQ = 4'd9;
  localparam logic [3:0] F_MUL = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ula_op_dec.sv
// ula_op_dec: decodes ALUop/func into the 4-bit ALU OP code.
// Latency: purely combinational.
// Backpressure: none; func 10 maps to mul only when ULA_MUL_EN is defined.
module ula_op_dec
  import ula_pkg::*;
(
  input  logic [5:0] func,
  input  logic [2:0] ALUop,
  output logic [3:0] op
);

  logic [3:0] func_op;
  logic       unused_func;

  // Only the low nibble of func selects an operation.
  assign unused_func = ^func[5:4];

  // Map the R-type function field onto an OP code.
  always_comb begin
    func_op = OP_ADD;
    case (func[3:0])
      F_ADD:   func_op = OP_ADD;
      F_SUB:   func_op = OP_SUB;
      F_NOR:   func_op = OP_NOR;
      F_OR:    func_op = OP_OR;
      F_AND:   func_op = OP_AND;
      F_XOR:   func_op = OP_XOR;
      F_SLL:   func_op = OP_SLL;
      F_SRL:   func_op = OP_SRL;
      F_SLT:   func_op = OP_SLT;
      F_SEQ:   func_op = OP_SEQ;
`ifdef ULA_MUL_EN
      F_MUL:   func_op = OP_MUL;
`endif
      default: func_op = OP_ADD;
    endcase
  end

  // Main control chooses add, sub, or defers to the function field.
  always_comb begin
    op = OP_ADD;
    case (ALUop)
      3'd1:    op = OP_SUB;
      3'd2:    op = func_op;
      default: op = OP_ADD;
    endcase
  end

endmodule

// File: rtl/ula_exec.sv
// ula_exec: multi-cycle ALU execute unit (single-cycle logic/arith, serial shift, optional mul).
// Latency: 1 cycle for one-cycle ops and shift-by-0, n for shift by n, WIDTH for mul (ULA_MUL_EN).
// Backpressure: result held in DONE until out_ready; in_ready low whenever not IDLE.
module ula_exec
  import ula_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       func,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  state_t           state;
  logic [3:0]       op;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;
  logic [SHW-1:0]   amt;
  logic             is_shift;
  logic [WIDTH-1:0] shift1;
  logic [WIDTH-1:0] work_next;
  logic [WIDTH-1:0] alu_res;

  ula_op_dec u_dec (
    .func  (func),
    .ALUop (ALUop),
    .op    (op)
  );

  assign amt      = b[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL);
  // The first shift step is taken on the accept edge, so a shift by n
  // reports after n cycles just like a one-cycle op reports after 1.
  assign shift1    = (op == OP_SLL) ? {a[WIDTH-2:0], 1'b0} : {1'b0, a[WIDTH-1:1]};
  assign work_next = (op_q == OP_SLL) ? {work[WIDTH-2:0], 1'b0} : {1'b0, work[WIDTH-1:1]};

`ifdef ULA_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
`endif

  // Single-cycle datapath on the live operands, used at accept time.
  always_comb begin
    alu_res = a + b;
    case (op)
      OP_SUB:         alu_res = a - b;
      OP_NOR:         alu_res = ~(a | b);
      OP_OR:          alu_res = a | b;
      OP_AND:         alu_res = a & b;
      OP_XOR:         alu_res = a ^ b;
      OP_SLL, OP_SRL: alu_res = (amt == '0) ? a : shift1;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SEQ:         alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default:        alu_res = a + b;
    endcase
  end

  // Control FSM with registered handshake outputs and the working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      op_q      <= OP_ADD;
      work      <= '0;
      count     <= '0;
      result    <= '0;
      zero      <= 1'b1;
`ifdef ULA_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (is_shift && (amt > SHW'(1))) begin
              work  <= shift1;
              count <= amt - SHW'(1);
              state <= S_SHIFT;
            end
`ifdef ULA_MUL_EN
            else if (op == OP_MUL) begin
              // First partial product folded into the accept edge.
              acc    <= b[0] ? a : '0;
              mcand  <= {a[WIDTH-2:0], 1'b0};
              mplier <= {1'b0, b[WIDTH-1:1]};
              count  <= SHW'(WIDTH - 1);
              state  <= S_MUL;
            end
`endif
            else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          if (count == SHW'(1)) begin
            result    <= work_next;
            zero      <= (work_next == '0);
            count     <= '0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            work  <= work_next;
            count <= count - SHW'(1);
          end
        end
`ifdef ULA_MUL_EN
        S_MUL: begin
          if (count == SHW'(1)) begin
            result    <= acc_next;
            zero      <= (acc_next == '0);
            count     <= '0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            acc    <= acc_next;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            count  <= count - SHW'(1);
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_exec.sv
// tb_ula_exec: self-checking bench for ula_exec against a behavioural ALU model.
// Latency: counted in cycles from the accept edge (accept edge itself = 1).
// Backpressure: exercised by holding out_ready low while offering new ops.
module tb_ula_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  func = '0;
  logic [2:0]  ALUop = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ula_exec #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .ALUop     (ALUop),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Effective function number: 0 add, 1 sub, otherwise the func nibble.
  function automatic int eff_fn(input logic [2:0] al, input logic [5:0] fn);
    if (al == 3'd2) return int'(fn[3:0]);
    if (al == 3'd1) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] al, input logic [5:0] fn,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [63:0] prod;
    case (eff_fn(al, fn))
      1:  return x - y;
      2:  return ~(x | y);
      3:  return x | y;
      4:  return x & y;
      5:  return x ^ y;
      6:  return x << y[4:0];
      7:  return x >> y[4:0];
      8:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      9:  return (x == y) ? 32'd1 : 32'd0;
`ifdef ULA_MUL_EN
      10: begin prod = {32'd0, x} * {32'd0, y}; return prod[31:0]; end
`endif
      default: return x + y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] al, input logic [5:0] fn, input logic [31:0] y);
    case (eff_fn(al, fn))
      6, 7: return (y[4:0] == 5'd0) ? 1 : int'(y[4:0]);
`ifdef ULA_MUL_EN
      10:   return 32;
`endif
      default: return 1;
    endcase
  endfunction

  // Present one op, wait for acceptance, then count cycles to out_valid.
  task automatic send(input logic [2:0] al, input logic [5:0] fn,
                      input logic [31:0] av, input logic [31:0] bv, output int lat);
    @(negedge clk);
    ALUop = al; func = fn; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; func = 6'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_in_reset: out_valid=%b busy=%b, want 0 0", out_valid, busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    int lat;
    send(3'd0, 6'd0, 32'd5, 32'd7, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
    checks++; if (result !== 32'd12 || zero !== 1'b0) begin errors++;
      $display("FAIL add_result: got %h/%b want 0000000c/0", result, zero); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++;
      $display("FAIL add_busy: busy=%b in_ready=%b want 1 0", busy, in_ready); end
    take();
  endtask

  task automatic test_decode();
    logic [2:0]  al [4] = '{3'd2, 3'd2, 3'd2, 3'd1};
    logic [5:0]  fn [4] = '{6'd8, 6'd9, 6'd2, 6'd0};
    logic [31:0] av [4] = '{32'hFFFFFFFF, 32'h1234, 32'd0, 32'h55AA};
    logic [31:0] bv [4] = '{32'd1, 32'h1234, 32'd0, 32'h55AA};
    logic [31:0] want [4] = '{32'd1, 32'd1, 32'hFFFFFFFF, 32'd0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(al[i], fn[i], av[i], bv[i], lat);
      checks++; if (result !== want[i] || zero !== (want[i] == 32'd0) || lat !== 1) begin errors++;
        $display("FAIL decode_%0d: got %h zero=%b lat=%0d want %h lat 1", i, result, zero, lat, want[i]); end
      take();
    end
  endtask

  task automatic test_shift();
    int lat;
    send(3'd2, 6'd6, 32'd1, 32'd31, lat);
    checks++; if (lat !== 31 || result !== 32'h80000000) begin errors++;
      $display("FAIL sll31: got %h lat=%0d want 80000000 lat 31", result, lat); end
    take();
    send(3'd2, 6'd7, 32'h80000000, 32'd0, lat);
    checks++; if (lat !== 1 || result !== 32'h80000000) begin errors++;
      $display("FAIL srl0: got %h lat=%0d want 80000000 lat 1", result, lat); end
    take();
    send(3'd2, 6'd7, 32'h80000000, 32'd2, lat);
    checks++; if (lat !== 2 || result !== 32'h20000000) begin errors++;
      $display("FAIL srl2: got %h lat=%0d want 20000000 lat 2", result, lat); end
    take();
  endtask

  task automatic test_mul();
    int lat;
    logic [31:0] want;
    want = ref_res(3'd2, 6'd10, 32'hFFFFFFFF, 32'd3);
    send(3'd2, 6'd10, 32'hFFFFFFFF, 32'd3, lat);
    checks++; if (lat !== ref_lat(3'd2, 6'd10, 32'd3) || result !== want) begin errors++;
      $display("FAIL func10: got %h lat=%0d want %h lat %0d", result, lat, want,
               ref_lat(3'd2, 6'd10, 32'd3)); end
    take();
  endtask

  task automatic test_random();
    logic [2:0]  al;
    logic [5:0]  fn;
    logic [31:0] av, bv, want;
    int lat, wlat;
    for (int i = 0; i < 40; i++) begin
      al = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) al = 3'd2;
      fn = 6'($urandom);
      av = $urandom;
      bv = ($urandom_range(0, 3) == 0) ? av : $urandom;
      want = ref_res(al, fn, av, bv);
      wlat = ref_lat(al, fn, bv);
      send(al, fn, av, bv, lat);
      checks++; if (result !== want || zero !== (want == 32'd0) || lat !== wlat) begin errors++;
        $display("FAIL random_%0d: ALUop=%0d func=%0d a=%h b=%h got %h z=%b lat=%0d want %h lat %0d",
                 i, al, fn, av, bv, result, zero, lat, want, wlat); end
      take();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit stable;
    send(3'd0, 6'd0, 32'd100, 32'd23, lat);
    // Offer a sub while the add result is stalled.
    ALUop = 3'd1; a = 32'd50; b = 32'd8; in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd123) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++;
      $display("FAIL backpressure_hold: result=%h out_valid=%b in_ready=%b want 0000007b 1 0",
               result, out_valid, in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL handshake_no_accept: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd42) begin errors++;
      $display("FAIL after_stall: got %h valid=%b want 0000002a 1", result, out_valid); end
    take();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    bit ok = 1'b1;
    @(negedge clk);
    ALUop = 3'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (result !== 32'd7) ok = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (pulses !== 4 || !ok) begin errors++;
      $display("FAIL back_to_back: pulses=%0d results_ok=%b want 4 1", pulses, ok); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    ALUop = 3'd2; func = 6'd6; a = 32'd1; b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin errors++;
      $display("FAIL midreset_async: busy=%b in_ready=%b result=%h want 0 1 0", busy, in_ready, result); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen || result !== 32'd0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL midreset_lost: out_valid_seen=%b result=%h in_ready=%b want 0 0 1", seen, result, in_ready); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode();
    test_shift();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_exec.md
# ula_exec

Parametrised, multi-cycle ALU execute unit for the MIPS datapath. It decodes `func`/`ALUop` into a 4-bit ALU operation and executes it on WIDTH-bit operands. Single-cycle ops complete in one cycle; shifts iterate one bit per cycle and an optional multiply runs shift-add. Sits between the register-read stage and writeback, with valid/ready handshakes on both sides so the control FSM can stall on long ops.

## Interface
- WIDTH, 32, operand/result width (≥ 4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  unit accepts a new op
- func  in  6  R-type function field; only func[3:0] decoded
- ALUop  in  3  main-control ALU selector
- a, b  in  WIDTH  operands; shift amount = b[SHW-1:0], shifts act on a
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- busy  out  1  state ≠ IDLE

## Operation
- Decode, 4-bit OP:
  - ALUop 0 → add 0000; 1 → sub 1000; 2 → from func; 3 → add; 4–7 → add.
  - func[3:0] map: 0 add 0000, 1 sub 1000, 2 nor 1011, 3 or 1001, 4 and 0001, 5 xor 1010, 6 sll 0100, 7 srl 1100, 8 slt 1110, 9 seq 1111, 10 mul 0110 (only with ULA_MUL_EN), others add.
- Arithmetic: add/sub are modulo 2^WIDTH, with no overflow trap.
- Compares: slt is a signed compare; result = {WIDTH-1 zeros, a<b}. seq gives result = {zeros, a==b}.
- Shifts: logical with zero fill; amounts ≥ WIDTH are impossible by width.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, operands and OP are latched.
    - Logic/arith/compare ops, or a shift with amount 0 → DONE, result computed and registered.
    - Shift with amount n>0 → SHIFT with count=n.
    - mul → MUL with count=WIDTH.
  - SHIFT: shift the working register one bit per cycle and decrement count. At count==1, write the final value to result → DONE.
  - MUL: each cycle, if the multiplier LSB is set, add the multiplicand to the accumulator. Multiplicand shifts left, multiplier shifts right, count decrements. At count==1 → DONE. Result is the low WIDTH bits of the product (same for signed/unsigned).
  - DONE: out_valid=1; result and zero are held stable. On out_ready → IDLE.
- in_ready is 0 in SHIFT, MUL and DONE. No new op is accepted in the same cycle as an output handshake.
- Inputs are ignored outside IDLE; a, b and func may change freely after acceptance.

## Timing
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, result=0, zero=1, busy=0, counters 0.
- Reset asserted mid-op aborts it; the op is lost and no out_valid is produced.
- Latency, from accept edge to out_valid high:
  - 1 cycle for single-cycle ops and shift-by-0.
  - n cycles for shift by n.
  - WIDTH cycles for mul.
- Minimum initiation interval is 2 cycles: accept, then DONE with out_ready=1.
- out_valid stays high until out_ready; back-pressure is unlimited.
- zero is valid only while out_valid=1 or after reset.

## Configuration
- ULA_MUL_EN defined:
  - func 10 decodes to mul; MUL state and accumulator are built.
- ULA_MUL_EN undefined:
  - func 10 decodes to add and completes in 1 cycle.
  - MUL state, accumulator and adder are absent.

## Structure
- Package ula_pkg:
  - OP code localparams (4-bit) for all ops above.
  - FSM state enum.
  - func code constants.
- Sub-module ula_op_dec: purely combinational func/ALUop → OP decoder, instantiated once. Its output is latched at accept.
- The ula_exec top holds the FSM, operand/working registers, counter and result register.

## Test plan
- Reset/add: hold rst_n=0, then release; check result=0, zero=1, in_ready=1. Then ALUop=0, a=5, b=7 → out_valid one cycle after accept, result=12, zero=0.
- Func decode with WIDTH=32:
  - ALUop=2, func=8 (slt), a=-1, b=1 → result=1.
  - func=9, a=b=0x1234 → result=1.
  - func=2 (nor), a=b=0 → result=0xFFFFFFFF.
- Shifts:
  - func=6, a=1, b=31 → out_valid 31 cycles after accept, result=0x80000000.
  - func=7, a=0x80000000, b=0 → latency 1, result=0x80000000.
- Back-pressure: out_ready=0 for 10 cycles after out_valid → result stable, in_ready=0, a second in_valid ignored. Then out_ready=1 → IDLE, next op accepted.
- Reset mid-shift: sll by 20, rst_n pulsed low at cycle 5 → out_valid never asserts, state IDLE, result=0.
- ULA_MUL_EN:
  - With macro: func=10, a=0xFFFFFFFF, b=3 → after 32 cycles, result=0xFFFFFFFD.
  - Without macro: same stimulus → latency 1, result=0x00000002 (add).
